ps2_host_tx: RTL

- PS/2 host-to-device transmitter; the opposite direction of the existing keyboard receiver.
- Sends single command bytes to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- Drives ps2_c/ps2_d through open-drain enables; the top level ties the pads low when an enable is set.
- busy lets the top level gate the keyboard receiver so it ignores frames while a transmit is in progress.

---
 rtl/ps2_host_tx.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (open-drain clock/data enables).
// Optional retry on failure when PS2_TX_RETRY_EN is defined.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int FILT_LEN       = 8
`ifdef PS2_TX_RETRY_EN
  ,
  parameter int MAX_RETRY      = 2
`endif
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_c_in,
  input  logic       ps2_d_in,
  output logic       ps2_c_oe,
  output logic       ps2_d_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILT_LEN + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INHIBIT   = 3'd1;
  localparam logic [2:0] RTS       = 3'd2;
  localparam logic [2:0] XFER      = 3'd3;
  localparam logic [2:0] ACK       = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  localparam logic [1:0] E_TIMEOUT = 2'b01;
  localparam logic [1:0] E_NOACK   = 2'b10;

  logic [2:0]    state;
  logic [7:0]    shift;
  logic          par;
  logic          dbit;
  logic [3:0]    n;
  logic [IW-1:0] icnt;
  logic [WW-1:0] wdog;

  logic          c_s1, c_s2, d_s1, d_s2;
  logic          c_f, d_f, c_fq;
  logic [FW-1:0] c_cnt, d_cnt;
  logic          fall;

  logic          fail;
  logic [1:0]    fail_code;
  logic          wd_hit;

`ifdef PS2_TX_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  logic [RW-1:0] retries;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c_s1 <= 1'b1;
      c_s2 <= 1'b1;
      d_s1 <= 1'b1;
      d_s2 <= 1'b1;
    end else begin
      c_s1 <= ps2_c_in;
      c_s2 <= c_s1;
      d_s1 <= ps2_d_in;
      d_s2 <= d_s1;
    end
  end

  // A new level is accepted only after FILT_LEN consecutive differing samples
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c_f   <= 1'b1;
      c_cnt <= '0;
    end else if (c_s2 == c_f) begin
      c_cnt <= '0;
    end else if (c_cnt == FW'(FILT_LEN - 1)) begin
      c_f   <= c_s2;
      c_cnt <= '0;
    end else begin
      c_cnt <= c_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d_f   <= 1'b1;
      d_cnt <= '0;
    end else if (d_s2 == d_f) begin
      d_cnt <= '0;
    end else if (d_cnt == FW'(FILT_LEN - 1)) begin
      d_f   <= d_s2;
      d_cnt <= '0;
    end else begin
      d_cnt <= d_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) c_fq <= 1'b1;
    else       c_fq <= c_f;
  end

  assign fall   = c_fq & ~c_f;
  assign wd_hit = (wdog == WW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    fail      = 1'b0;
    fail_code = 2'b00;
    case (state)
      XFER: begin
        if (!fall && wd_hit) begin
          fail      = 1'b1;
          fail_code = E_TIMEOUT;
        end
      end
      ACK: begin
        if (fall && d_f) begin
          fail      = 1'b1;
          fail_code = E_NOACK;
        end else if (!fall && wd_hit) begin
          fail      = 1'b1;
          fail_code = E_TIMEOUT;
        end
      end
      WAIT_IDLE: begin
        if (!(c_f && d_f) && !fall && wd_hit) begin
          fail      = 1'b1;
          fail_code = E_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      shift    <= '0;
      par      <= 1'b0;
      dbit     <= 1'b0;
      n        <= '0;
      icnt     <= '0;
      wdog     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
`ifdef PS2_TX_RETRY_EN
      retries  <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            shift <= tx_data;
            par   <= ~^tx_data;
            icnt  <= '0;
            state <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
            retries <= '0;
`endif
          end
        end
        INHIBIT: begin
          if (icnt == IW'(INHIBIT_CYCLES - 1)) begin
            icnt  <= '0;
            state <= RTS;
          end else begin
            icnt <= icnt + 1'b1;
          end
        end
        RTS: begin
          dbit  <= 1'b1;
          n     <= '0;
          wdog  <= '0;
          state <= XFER;
        end
        XFER: begin
          if (fall) begin
            wdog <= '0;
            n    <= n + 1'b1;
            if (n < 4'd8) begin
              dbit <= ~shift[n[2:0]];
            end else if (n == 4'd8) begin
              dbit <= ~par;
            end else begin
              dbit  <= 1'b0;
              state <= ACK;
            end
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        ACK: begin
          if (fall) begin
            wdog  <= '0;
            state <= WAIT_IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (c_f && d_f) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (fall) begin
            wdog <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (fail) begin
        dbit <= 1'b0;
        wdog <= '0;
`ifdef PS2_TX_RETRY_EN
        if (retries < RW'(MAX_RETRY)) begin
          retries <= retries + 1'b1;
          icnt    <= '0;
          state   <= INHIBIT;
        end else begin
          err      <= 1'b1;
          err_code <= fail_code;
          state    <= IDLE;
        end
`else
        err      <= 1'b1;
        err_code <= fail_code;
        state    <= IDLE;
`endif
      end
    end
  end

  assign tx_ready = (state == IDLE);
  assign busy     = ~tx_ready;
  assign ps2_c_oe = (state == INHIBIT) | (state == RTS);
  assign ps2_d_oe = (state == RTS) | ((state == XFER) & dbit);

endmodule
